// File: rtl/mem_arbiter.sv
// Shared memory port arbiter for fetch and data requesters.
// Data wins by default; a starved fetch eventually takes priority.
module mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    input  logic [3:0]      d_we,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] lat_cnt, lat_nxt;
    logic       owner, owner_nxt;
    logic [2:0] starve_cnt, starve_nxt;

    logic open_win;
    logic i_first;
    logic i_pick;
    logic d_pick;
    logic rd_gnt;
    logic resp;

    // Grant decode, response steering and next-state selection.
    always_comb begin
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        state_nxt  = state;
        lat_nxt    = lat_cnt;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;

        open_win = reset && (state == IDLE || lat_cnt == 2'd0);
        i_first  = (starve_cnt == 3'(STARVE_LIM));
        i_pick   = i_req && (i_first || !d_req);
        d_pick   = d_req && !(i_req && i_first);

        if (open_win) begin
            unique case (1'b1)
                i_pick:  i_gnt = 1'b1;
                d_pick:  d_gnt = 1'b1;
                default: ;
            endcase
        end

        rd_gnt = i_gnt || (d_gnt && d_we == 4'b0000);

        resp     = reset && state == WAIT && lat_cnt == 2'd0;
        busy     = reset && state == WAIT && lat_cnt != 2'd0;
        i_rvalid = resp && !owner;
        d_rvalid = resp && owner;
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;

        mem_req   = i_gnt || d_gnt;
        mem_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
        mem_we    = d_gnt ? d_we : 4'b0000;
        mem_wdata = d_gnt ? d_wdata : '0;

        if (state == WAIT && lat_cnt != 2'd0) begin
            lat_nxt = lat_cnt - 2'd1;
        end else if (rd_gnt) begin
            state_nxt = WAIT;
            lat_nxt   = 2'(MEM_LAT - 1);
            owner_nxt = d_gnt;
        end else begin
            state_nxt = IDLE;
        end

        if (i_gnt || !i_req) begin
            starve_nxt = 3'd0;
        end else if (d_gnt && starve_cnt < 3'(STARVE_LIM)) begin
            starve_nxt = starve_cnt + 3'd1;
        end
    end

    // State, latency, owner and starvation registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lat_cnt    <= 2'd0;
            owner      <= 1'b0;
            starve_cnt <= 3'd0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LAT 1, 2 and 3.
// Instance k has MEM_LAT k+1; all share the same inputs.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    logic [2:0]  i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, busy;
    logic [31:0] i_rdata   [3];
    logic [31:0] d_rdata   [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [3:0]  mem_we    [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_arbiter #(
            .XLEN(32),
            .MEM_LAT(g + 1),
            .STARVE_LIM(3)
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .i_req(i_req),
            .i_addr(i_addr),
            .i_gnt(i_gnt[g]),
            .i_rvalid(i_rvalid[g]),
            .i_rdata(i_rdata[g]),
            .d_req(d_req),
            .d_addr(d_addr),
            .d_we(d_we),
            .d_wdata(d_wdata),
            .d_gnt(d_gnt[g]),
            .d_rvalid(d_rvalid[g]),
            .d_rdata(d_rdata[g]),
            .mem_req(mem_req[g]),
            .mem_addr(mem_addr[g]),
            .mem_we(mem_we[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata),
            .busy(busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = 32'hC0DE_0000 + 32'(cyc);
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_addr  = '0;
        d_we    = 4'b0000;
        d_wdata = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic check_quiet(input string tag, input int k);
        check({tag, "_igt"}, 32'(i_gnt[k]), 0);
        check({tag, "_dgt"}, 32'(d_gnt[k]), 0);
        check({tag, "_irv"}, 32'(i_rvalid[k]), 0);
        check({tag, "_drv"}, 32'(d_rvalid[k]), 0);
        check({tag, "_mrq"}, 32'(mem_req[k]), 0);
        check({tag, "_mad"}, mem_addr[k], 0);
        check({tag, "_mwe"}, 32'(mem_we[k]), 0);
        check({tag, "_mwd"}, mem_wdata[k], 0);
        check({tag, "_bsy"}, 32'(busy[k]), 0);
        check({tag, "_ird"}, i_rdata[k], 0);
        check({tag, "_drd"}, d_rdata[k], 0);
    endtask

    initial begin
        reset     = 1'b0;
        mem_rdata = 32'hC0DE_0000;
        idle_inputs();

        // Reset state with live requests: grants must stay low.
        i_req  = 1'b1;
        d_req  = 1'b1;
        i_addr = 32'h1234;
        d_addr = 32'h5678;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_quiet("rst", k);
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        check_quiet("rel", 0);

        // Back-to-back fetch reads at MEM_LAT=1.
        do_reset();
        i_req  = 1'b1;
        i_addr = 32'h4000_0000;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            if (c == 3) i_req = 1'b0;
            @(negedge clk);
            check("f_igt", 32'(i_gnt[0]), (c < 3) ? 1 : 0);
            check("f_irv", 32'(i_rvalid[0]), (c >= 1 && c <= 3) ? 1 : 0);
            check("f_ird", i_rdata[0],
                  (c >= 1 && c <= 3) ? mem_rdata : 32'h0);
            check("f_mad", mem_addr[0], (c < 3) ? 32'h4000_0000 : 32'h0);
            check("f_mwe", 32'(mem_we[0]), 0);
            check("f_drv", 32'(d_rvalid[0]), 0);
        end

        // Data read at MEM_LAT=3 blocks a pending fetch.
        do_reset();
        i_req  = 1'b1;
        i_addr = 32'h80;
        d_req  = 1'b1;
        d_addr = 32'h100;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next_cycle();
            if (c == 1) d_req = 1'b0;
            @(negedge clk);
            check("l3_dgt", 32'(d_gnt[2]), (c == 0) ? 1 : 0);
            check("l3_igt", 32'(i_gnt[2]), (c == 3) ? 1 : 0);
            check("l3_bsy", 32'(busy[2]), (c == 1 || c == 2) ? 1 : 0);
            check("l3_drv", 32'(d_rvalid[2]), (c == 3) ? 1 : 0);
            check("l3_drd", d_rdata[2], (c == 3) ? mem_rdata : 32'h0);
            check("l3_irv", 32'(i_rvalid[2]), 0);
            if (c == 0) check("l3_mad", mem_addr[2], 32'h100);
        end

        // Byte-masked write beats fetch, no response phase.
        do_reset();
        i_req   = 1'b1;
        i_addr  = 32'h44;
        d_req   = 1'b1;
        d_addr  = 32'h200;
        d_we    = 4'b0011;
        d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("w_dgt", 32'(d_gnt[0]), 1);
        check("w_igt", 32'(i_gnt[0]), 0);
        check("w_mwe", 32'(mem_we[0]), 32'h3);
        check("w_mwd", mem_wdata[0], 32'hDEAD_BEEF);
        check("w_mad", mem_addr[0], 32'h200);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check("w_igt1", 32'(i_gnt[0]), 1);
        check("w_drv1", 32'(d_rvalid[0]), 0);
        check("w_mwe1", 32'(mem_we[0]), 0);
        check("w_mwd1", mem_wdata[0], 0);
        check("w_mad1", mem_addr[0], 32'h44);
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        check("w_drv2", 32'(d_rvalid[0]), 0);
        check("w_irv2", 32'(i_rvalid[0]), 1);

        // Starvation: fetch wins every fourth cycle under contention.
        do_reset();
        i_req  = 1'b1;
        i_addr = 32'h300;
        d_req  = 1'b1;
        d_addr = 32'h400;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            check("s_igt", 32'(i_gnt[0]), (c % 4 == 3) ? 1 : 0);
            check("s_dgt", 32'(d_gnt[0]), (c % 4 == 3) ? 0 : 1);
            if (c > 0) begin
                check("s_irv", 32'(i_rvalid[0]), (c % 4 == 0) ? 1 : 0);
                check("s_drv", 32'(d_rvalid[0]), (c % 4 == 0) ? 0 : 1);
            end
        end

        // Reset mid-read at MEM_LAT=2 drops the response.
        do_reset();
        d_req  = 1'b1;
        d_addr = 32'h500;
        @(negedge clk);
        check("r_dgt", 32'(d_gnt[1]), 1);
        next_cycle();
        d_req = 1'b0;
        #1;
        check("r_bsy", 32'(busy[1]), 1);
        #1;
        reset = 1'b0;
        i_req = 1'b1;
        @(negedge clk);
        check_quiet("r_in", 1);
        next_cycle();
        @(negedge clk);
        check_quiet("r_in2", 1);
        next_cycle();
        i_req = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            check("r_drv", 32'(d_rvalid[1]), 0);
            check("r_irv", 32'(i_rvalid[1]), 0);
            check("r_bsy2", 32'(busy[1]), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: address and data width.
REQ-002 The block SHALL have parameter MEM_LAT, default 1, legal 1..4: cycles from memory read issue to read-data valid.
REQ-003 The block SHALL have parameter STARVE_LIM, default 3, legal 1..7: consecutive lost fetch cycles before fetch wins priority.
REQ-004 The block SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have ports i_req, input, 1 and i_addr, input, XLEN: instruction-fetch read request and word address.
REQ-007 The block SHALL have ports i_gnt, output, 1; i_rvalid, output, 1; i_rdata, output, XLEN: fetch grant, read-data valid, read data.
REQ-008 The block SHALL have ports d_req, input, 1; d_addr, input, XLEN; d_we, input, 4; d_wdata, input, XLEN: data request; d_we==0 is a read, otherwise a byte-masked write.
REQ-009 The block SHALL have ports d_gnt, output, 1; d_rvalid, output, 1; d_rdata, output, XLEN: data grant, read-data valid, read data.
REQ-010 The block SHALL have ports mem_req, output, 1; mem_addr, output, XLEN; mem_we, output, 4; mem_wdata, output, XLEN; mem_rdata, input, XLEN: the single shared memory port.
REQ-011 The block SHALL have port busy, output, 1: a read is outstanding and no new grant is possible this cycle.

Function
REQ-012 The block SHALL issue at most one grant per cycle; i_gnt and d_gnt are never high together.
REQ-013 The block SHALL evaluate grants combinationally from req inputs and FSM state in the same cycle; the granted requester's addr/we/wdata drive mem_* in that cycle with mem_req=1.
REQ-014 The block SHALL force mem_we=0 on a fetch grant, and drive mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 when no grant is issued.
REQ-015 The block SHALL give priority to d_req over i_req unless starve_cnt==STARVE_LIM, in which case i_req wins.
REQ-016 The block SHALL keep a 3-bit starve_cnt: +1 in each cycle i_req=1 and d_gnt=1; cleared on i_gnt=1 or i_req=0; saturates at STARVE_LIM.
REQ-017 The block SHALL implement FSM states IDLE and WAIT, plus a 2-bit latency counter lat_cnt and a 1-bit owner register (0=fetch, 1=data).
REQ-018 IDLE: a read grant SHALL move to WAIT, load lat_cnt=MEM_LAT-1, and record owner; a write grant SHALL stay in IDLE with no response phase.
REQ-019 WAIT with lat_cnt>0: the block SHALL decrement lat_cnt, hold busy=1, and issue no grant.
REQ-020 WAIT with lat_cnt==0: the block SHALL assert the owner's rvalid for exactly one cycle with rdata=mem_rdata, and in that same cycle SHALL evaluate grants as in IDLE (back-to-back); next state WAIT if a read is granted, else IDLE.
REQ-021 With MEM_LAT=1 the block SHALL sustain one read grant per cycle.
REQ-022 busy SHALL equal 1 exactly when state==WAIT and lat_cnt>0.
REQ-023 The non-owner's rvalid SHALL be 0; i_rdata and d_rdata SHALL be 0 whenever their rvalid is 0.
REQ-024 A requester SHALL hold req/addr/we/wdata stable until granted; the block SHALL not latch requests and SHALL not grant a req deasserted before grant.

Reset
REQ-025 While reset=0 the block SHALL hold state=IDLE, lat_cnt=0, owner=0, starve_cnt=0, and drive all outputs to 0, including the combinational grants.
REQ-026 When reset is asserted mid-read, the outstanding read SHALL be dropped, with no rvalid after reset release.
REQ-027 The first grant after reset release SHALL occur no earlier than the first rising clk edge with reset=1.

Verification
REQ-028 MEM_LAT=1: i_req=1 with i_addr=0x40000000 held for 3 cycles -> i_gnt=1 in cycles 0,1,2; i_rvalid=1 in cycles 1,2,3 with i_rdata=mem_rdata.
REQ-029 MEM_LAT=3: d_req read at 0x100 in cycle 0 -> d_gnt=1 in cycle 0; busy=1 in cycles 1,2; d_rvalid=1 in cycle 3; no grant to a pending i_req in cycles 1-2.
REQ-030 i_req=1 and d_req=1 simultaneously with d_we=4'b0011 -> d_gnt=1 with mem_we=4'b0011 and mem_wdata=d_wdata; i_gnt=1 in the next cycle; no d_rvalid.
REQ-031 STARVE_LIM=3, i_req and d_req both held continuously -> d_gnt in cycles 0,1,2; i_gnt in cycle 3; starve_cnt=0 in cycle 4, after which d wins again.
REQ-032 MEM_LAT=2: read granted in cycle 0, reset=0 asynchronously in cycle 1, released in cycle 3 -> no rvalid in any cycle; all outputs 0 during reset; busy=0 after release.
